// File: rtl/fifo_pkg.sv
// Shared asynchronous-FIFO helpers: pointer width and binary/Gray conversions.
// Used by both the write-side and read-side pointer controllers.
package fifo_pkg;

    // Conversions operate on a wide word; callers zero-extend their pointer
    // into it and truncate the result back to their pointer width.
    localparam int PTR_WORD_W = 32;
    typedef logic [PTR_WORD_W-1:0] ptr_word_t;

    // Pointers carry one extra wrap bit above the memory address.
    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic ptr_word_t bin2gray(input ptr_word_t bin);
        return bin ^ (bin >> 1);
    endfunction

    // XOR prefix from the MSB down.
    function automatic ptr_word_t gray2bin(input ptr_word_t gray);
        ptr_word_t bin;
        bin[PTR_WORD_W-1] = gray[PTR_WORD_W-1];
        for (int i = PTR_WORD_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_gray_cnt.sv
// Binary/Gray pointer register with increment enable, reset to zero.
// Exposes both the registered pointer and its next value so the owner can
// evaluate flags on the pointer as it will be after the current edge.
module fifo_gray_cnt
    import fifo_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] bin_q,
    output logic [W-1:0] gray_q,
    output logic [W-1:0] bin_nxt,
    output logic [W-1:0] gray_nxt
);

    logic [W-1:0] bin_d;
    logic [W-1:0] gray_d;

    // Next pointer wraps naturally modulo 2^W; Gray derived from it.
    always_comb begin
        bin_d  = bin_q + W'(inc);
        gray_d = W'(bin2gray(ptr_word_t'(bin_d)));
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= '0;
            gray_q <= '0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
        end
    end

    assign bin_nxt  = bin_d;
    assign gray_nxt = gray_d;

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of the asynchronous FIFO (write clock domain).
// Produces the memory write strobe/address, the Gray write pointer for the
// read-domain synchronizer, a registered FULL flag and a sticky overflow flag.
// Optional macro FIFO_WR_AFULL_EN adds a registered ALMOST_FULL output.
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 3
`ifdef FIFO_WR_AFULL_EN
    ,
    parameter int AFULL_THRESH = 6
`endif
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  W_INC,
    input  logic [ADDR_WIDTH:0]   RD_PTR_SYNC,
    output logic                  W_EN,
    output logic [ADDR_WIDTH-1:0] W_ADDR,
    output logic [ADDR_WIDTH:0]   WR_PTR_GRAY,
    output logic                  FULL,
    output logic                  OVF_ERR
`ifdef FIFO_WR_AFULL_EN
    ,
    output logic                  ALMOST_FULL
`endif
);

    localparam int PW = ptr_width(ADDR_WIDTH);

    // Full when the next write pointer equals the read pointer with its two
    // top Gray bits inverted (same address, opposite wrap). For a 2-bit
    // pointer this inverts both bits.
    localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);

    logic [PW-1:0] wr_bin_q;
    logic [PW-1:0] wr_gray_q;
    logic [PW-1:0] wr_bin_nxt;
    logic [PW-1:0] wr_gray_nxt;
    logic          full_d;
    logic          full_q;
    logic          ovf_d;
    logic          ovf_q;

    // A write while full is dropped, so the pointer never passes the reader.
    assign W_EN = W_INC & ~full_q;

    fifo_gray_cnt #(
        .W (PW)
    ) u_wr_ptr (
        .clk      (CLK),
        .rst_n    (RST),
        .inc      (W_EN),
        .bin_q    (wr_bin_q),
        .gray_q   (wr_gray_q),
        .bin_nxt  (wr_bin_nxt),
        .gray_nxt (wr_gray_nxt)
    );

    // Flag next-state: full on the post-write pointer vs current read pointer.
    always_comb begin
        full_d = (wr_gray_nxt == (RD_PTR_SYNC ^ FULL_MASK));
        ovf_d  = ovf_q | (W_INC & full_q);
    end

    // Flag registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            full_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            full_q <= full_d;
            ovf_q  <= ovf_d;
        end
    end

`ifdef FIFO_WR_AFULL_EN
    localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);

    logic [PW-1:0] rd_bin;
    logic [PW-1:0] level_nxt;
    logic          afull_d;
    logic          afull_q;
    logic          unused_wrap_bit;

    // Fill level after this edge, measured against the synchronized reader.
    always_comb begin
        rd_bin    = PW'(gray2bin(ptr_word_t'(RD_PTR_SYNC)));
        level_nxt = wr_bin_nxt - rd_bin;
        afull_d   = (level_nxt >= AFULL_LVL);
    end

    // Almost-full register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            afull_q <= 1'b0;
        end else begin
            afull_q <= afull_d;
        end
    end

    assign ALMOST_FULL     = afull_q;
    assign unused_wrap_bit = wr_bin_q[ADDR_WIDTH];
`else
    logic unused_ptr_bits;
    assign unused_ptr_bits = ^{wr_bin_q[ADDR_WIDTH], wr_bin_nxt};
`endif

    assign W_ADDR      = wr_bin_q[ADDR_WIDTH-1:0];
    assign WR_PTR_GRAY = wr_gray_q;
    assign FULL        = full_q;
    assign OVF_ERR     = ovf_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Testbench for fifo_wr_ctrl (ADDR_WIDTH=3, AFULL_THRESH=6).
// Reference model tracks write/read counts as integers and derives the
// fill level, FULL, OVF_ERR and ALMOST_FULL from plain arithmetic.
module tb_fifo_wr_ctrl;

    localparam int A  = 3;
    localparam int PW = A + 1;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          W_INC = 1'b0;
    logic [PW-1:0] RD_PTR_SYNC = '0;
    logic          W_EN;
    logic [A-1:0]  W_ADDR;
    logic [PW-1:0] WR_PTR_GRAY;
    logic          FULL;
    logic          OVF_ERR;
`ifdef FIFO_WR_AFULL_EN
    logic          ALMOST_FULL;
`endif

    fifo_wr_ctrl #(
        .ADDR_WIDTH   (A)
`ifdef FIFO_WR_AFULL_EN
        ,
        .AFULL_THRESH (6)
`endif
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .W_INC       (W_INC),
        .RD_PTR_SYNC (RD_PTR_SYNC),
        .W_EN        (W_EN),
        .W_ADDR      (W_ADDR),
        .WR_PTR_GRAY (WR_PTR_GRAY),
        .FULL        (FULL),
        .OVF_ERR     (OVF_ERR)
`ifdef FIFO_WR_AFULL_EN
        ,
        .ALMOST_FULL (ALMOST_FULL)
`endif
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // Reference model state: entries written / read, modulo 16.
    int m_wptr;
    int m_rdp;
    bit m_full;
    bit m_ovf;
    bit m_af;

    function automatic logic [3:0] to_gray(input int b);
        logic [3:0] v;
        v = 4'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_wptr = 0;
        m_rdp  = 0;
        m_full = 0;
        m_ovf  = 0;
        m_af   = 0;
    endtask

    // One clock cycle: drive request and read pointer, check the same-cycle
    // strobe/address, then check registered state after the edge.
    task automatic step(input bit inc, input int rdp);
        logic [PW-1:0] prev_gray;
        bit            wen;
        int            lvl;
        @(negedge CLK);
        m_rdp       = rdp & 15;
        W_INC       = inc;
        RD_PTR_SYNC = to_gray(m_rdp);
        #1;
        wen = inc && !m_full;
        check("w_en", 32'(W_EN), 32'(wen));
        check("w_addr_req", 32'(W_ADDR), 32'(m_wptr & 7));
        prev_gray = WR_PTR_GRAY;
        @(posedge CLK);
        if (inc && m_full) m_ovf = 1;
        if (wen) m_wptr = (m_wptr + 1) & 15;
        lvl    = (m_wptr - m_rdp) & 15;
        m_full = (lvl == 8);
        m_af   = (lvl >= 6);
        #1;
        check("wr_gray", 32'(WR_PTR_GRAY), 32'(to_gray(m_wptr)));
        check("w_addr", 32'(W_ADDR), 32'(m_wptr & 7));
        check("full", 32'(FULL), 32'(m_full));
        check("ovf_err", 32'(OVF_ERR), 32'(m_ovf));
        check("gray_1bit", 32'($countones(prev_gray ^ WR_PTR_GRAY) <= 1), 32'(1));
`ifdef FIFO_WR_AFULL_EN
        check("almost_full", 32'(ALMOST_FULL), 32'(m_af));
`endif
    endtask

    // Assert reset between edges and check outputs clear without a clock.
    task automatic reset_check();
        #2;
        RST   = 1'b0;
        W_INC = 1'b1;
        #1;
        check("rst_gray", 32'(WR_PTR_GRAY), 32'(0));
        check("rst_addr", 32'(W_ADDR), 32'(0));
        check("rst_full", 32'(FULL), 32'(0));
        check("rst_ovf", 32'(OVF_ERR), 32'(0));
        check("rst_w_en", 32'(W_EN), 32'(1));
`ifdef FIFO_WR_AFULL_EN
        check("rst_afull", 32'(ALMOST_FULL), 32'(0));
`endif
        model_reset();
        @(negedge CLK);
        W_INC = 1'b0;
        RST   = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit full_seen;
        model_reset();
        reset_check();

        // Reset in the middle of operation.
        for (int i = 0; i < 3; i++) step(1, 0);
        check("pre_rst_addr", 32'(W_ADDR), 32'(3));
        reset_check();

        // Fill from empty.
        for (int i = 0; i < 8; i++) step(1, 0);
        check("fill_gray", 32'(WR_PTR_GRAY), 32'(4'b1100));
        check("fill_full", 32'(FULL), 32'(1));

        // Overflow attempt is dropped and flagged.
        step(1, 0);
        check("ovf_set", 32'(OVF_ERR), 32'(1));
        check("ovf_gray_hold", 32'(WR_PTR_GRAY), 32'(4'b1100));
        step(0, 0);
        check("ovf_sticky", 32'(OVF_ERR), 32'(1));

        // Release by reader progress, then refill with one write.
        step(0, 1);
        check("release_full", 32'(FULL), 32'(0));
        step(1, 1);
        check("refill_full", 32'(FULL), 32'(1));
        check("refill_addr", 32'(W_ADDR), 32'(1));

        // Wrap with the reader two entries behind.
        reset_check();
        full_seen = 0;
        for (int i = 0; i < 16; i++) begin
            step(1, (m_wptr - 2) & 15);
            full_seen |= FULL;
        end
        check("wrap_gray", 32'(WR_PTR_GRAY), 32'(0));
        check("wrap_no_full", 32'(full_seen), 32'(0));

`ifdef FIFO_WR_AFULL_EN
        // Almost-full threshold crossing and release.
        reset_check();
        for (int i = 0; i < 5; i++) step(1, 0);
        check("af_at5", 32'(ALMOST_FULL), 32'(0));
        step(1, 0);
        check("af_at6", 32'(ALMOST_FULL), 32'(1));
        step(0, 1);
        check("af_release", 32'(ALMOST_FULL), 32'(0));
`endif

        // Randomized traffic with a reader that never overtakes the writer.
        reset_check();
        for (int i = 0; i < 400; i++) begin
            int rdp;
            bit inc;
            rdp = m_rdp;
            if (((m_wptr - m_rdp) & 15) != 0 && $urandom_range(0, 2) == 0)
                rdp = (m_rdp + 1) & 15;
            inc = ($urandom_range(0, 3) != 0);
            step(inc, rdp);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
